// File: rtl/sad_acc_if.sv
// Handshake bundle between the SAD source, the block accumulator and its consumer.
// The out_max signal is present only when SAD_ACC_MAX_EN is defined.
interface sad_acc_if #(
  parameter int unsigned W    = 8,
  parameter int unsigned LOGN = 4
);
  logic                in_vld;
  logic [W+1:0]        in_data;
  logic                in_rdy;
  logic                flush;
  logic                out_vld;
  logic                out_rdy;
  logic [W+1+LOGN:0]   out_sum;
  logic [LOGN:0]       out_cnt;
`ifdef SAD_ACC_MAX_EN
  logic [W+1:0]        out_max;

  modport master (
    output in_vld, in_data, flush, out_rdy,
    input  in_rdy, out_vld, out_sum, out_cnt, out_max
  );
  modport slave (
    input  in_vld, in_data, flush, out_rdy,
    output in_rdy, out_vld, out_sum, out_cnt, out_max
  );
`else
  modport master (
    output in_vld, in_data, flush, out_rdy,
    input  in_rdy, out_vld, out_sum, out_cnt
  );
  modport slave (
    input  in_vld, in_data, flush, out_rdy,
    output in_rdy, out_vld, out_sum, out_cnt
  );
`endif
endinterface

// File: rtl/sad_acc.sv
// Accumulates blocks of N = 2^LOGN SAD samples into one registered result, with flush support.
// Define SAD_ACC_MAX_EN to also report the per-block maximum sample on out_max.
module sad_acc #(
  parameter int unsigned W    = 8,
  parameter int unsigned LOGN = 4
) (
  input logic     clk,
  input logic     rst,
  sad_acc_if.slave bus
);
  localparam int unsigned N  = 2 ** LOGN;
  localparam int unsigned DW = W + 2;
  localparam int unsigned SW = W + 2 + LOGN;
  localparam int unsigned CW = LOGN + 1;

  typedef enum logic {StEmpty, StFull} state_e;

  state_e        r_state, w_state_d;
  logic [SW-1:0] r_acc, w_acc_d, r_out_sum, w_out_sum_d, w_sum_inc;
  logic [CW-1:0] r_cnt, w_cnt_d, r_out_cnt, w_out_cnt_d, w_cnt_inc;
  logic          w_out_vld, w_in_rdy, w_accept, w_flush, w_final, w_emit;

  assign w_out_vld = (r_state == StFull);
  // Ready is forced high while in reset so upstream never sees a stall then.
  assign w_in_rdy  = rst | ~w_out_vld | bus.out_rdy;
  assign w_accept  = bus.in_vld & w_in_rdy;
  assign w_flush   = bus.flush & w_in_rdy;
  assign w_sum_inc = r_acc + SW'(bus.in_data);
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_final   = w_accept & (r_cnt == CW'(N - 1));
  // A flush on an empty block with no sample produces nothing.
  assign w_emit    = w_final | (w_flush & (w_accept | (r_cnt != '0)));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StEmpty: if (w_emit) w_state_d = StFull;
      StFull:  if (bus.out_rdy && !w_emit) w_state_d = StEmpty;
      default: w_state_d = StEmpty;
    endcase
  end

  always_comb begin
    w_acc_d     = r_acc;
    w_cnt_d     = r_cnt;
    w_out_sum_d = r_out_sum;
    w_out_cnt_d = r_out_cnt;
    if (w_emit) begin
      w_out_sum_d = w_accept ? w_sum_inc : r_acc;
      w_out_cnt_d = w_accept ? w_cnt_inc : r_cnt;
      w_acc_d     = '0;
      w_cnt_d     = '0;
    end else if (w_accept) begin
      w_acc_d = w_sum_inc;
      w_cnt_d = w_cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StEmpty;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_out_sum <= '0;
      r_out_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_acc     <= w_acc_d;
      r_cnt     <= w_cnt_d;
      r_out_sum <= w_out_sum_d;
      r_out_cnt <= w_out_cnt_d;
    end
  end

`ifdef SAD_ACC_MAX_EN
  logic [DW-1:0] r_max, w_max_d, r_out_max, w_out_max_d, w_max_inc;

  assign w_max_inc = (w_accept && (bus.in_data > r_max)) ? bus.in_data : r_max;

  always_comb begin
    w_max_d     = r_max;
    w_out_max_d = r_out_max;
    if (w_emit) begin
      w_out_max_d = w_max_inc;
      w_max_d     = '0;
    end else if (w_accept) begin
      w_max_d = w_max_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max     <= '0;
      r_out_max <= '0;
    end else begin
      r_max     <= w_max_d;
      r_out_max <= w_out_max_d;
    end
  end

  assign bus.out_max = r_out_max;
`endif

  assign bus.in_rdy  = w_in_rdy;
  assign bus.out_vld = w_out_vld;
  assign bus.out_sum = r_out_sum;
  assign bus.out_cnt = r_out_cnt;
endmodule

// File: tb/tb_sad_acc.sv
// Scoreboard bench for sad_acc: a block-level model predicts results, a monitor checks them.
module tb_sad_acc;
  localparam int unsigned W    = 8;
  localparam int unsigned LOGN = 2;
  localparam int unsigned N    = 2 ** LOGN;
  localparam int unsigned DW   = W + 2;
  localparam int unsigned SW   = W + 2 + LOGN;
  localparam int unsigned CW   = LOGN + 1;

  typedef struct {
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt;
    logic [DW-1:0] mx;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sad_acc_if #(.W(W), .LOGN(LOGN)) bus ();
  sad_acc #(.W(W), .LOGN(LOGN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_chk  = 0;
  int   n_fail = 0;
  res_t exp_q[$];
  int   blk[$];      // samples of the block being collected
  bit   m_pend = 0;  // a result is waiting at the output

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", nm, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model decides what the next edge must do.
  task automatic cyc(input logic vld, input logic [DW-1:0] data, input logic fl,
                     input logic ordy, input logic r);
    bit   pend_before, rdy, acc_ok, fl_ok;
    res_t e;
    int   s, m;
    @(posedge clk);
    #2;
    bus.in_vld  = vld;
    bus.in_data = data;
    bus.flush   = fl;
    bus.out_rdy = ordy;
    rst         = r;
    pend_before = m_pend;
    rdy         = !m_pend || ordy;
    if (r) begin
      blk.delete();
      exp_q.delete();
      m_pend = 0;
    end else begin
      acc_ok = vld && rdy;
      fl_ok  = fl && rdy;
      if (acc_ok) blk.push_back(int'(data));
      if ((acc_ok && blk.size() == N) || (fl_ok && blk.size() > 0)) begin
        s = 0;
        m = 0;
        foreach (blk[i]) begin
          s += blk[i];
          if (blk[i] > m) m = blk[i];
        end
        e.sum = SW'(s);
        e.cnt = CW'(blk.size());
        e.mx  = DW'(m);
        exp_q.push_back(e);
        blk.delete();
        m_pend = 1;
      end else if (m_pend && ordy) begin
        m_pend = 0;
      end
    end
    #1;
    chk("in_rdy", 32'(bus.in_rdy), r ? 32'd1 : 32'(rdy));
    if (!r) chk("out_vld", 32'(bus.out_vld), 32'(pend_before));
  endtask

  task automatic put(input int v, input logic ordy);
    cyc(1'b1, DW'(v), 1'b0, ordy, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, '0, 1'b0, ordy, 1'b0);
  endtask

  // Monitor: compare the head of the scoreboard whenever a result is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.out_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(bus.out_sum), 32'hFFFF_FFFF);
        end else begin
          chk("out_sum", 32'(bus.out_sum), 32'(exp_q[0].sum));
          chk("out_cnt", 32'(bus.out_cnt), 32'(exp_q[0].cnt));
`ifdef SAD_ACC_MAX_EN
          chk("out_max", 32'(bus.out_max), 32'(exp_q[0].mx));
`endif
          if (bus.out_rdy === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.in_vld  = 1'b0;
    bus.in_data = '0;
    bus.flush   = 1'b0;
    bus.out_rdy = 1'b0;
    cyc(1'b1, DW'(77), 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    chk("reset_out_sum", 32'(bus.out_sum), 32'd0);
    chk("reset_out_cnt", 32'(bus.out_cnt), 32'd0);
`ifdef SAD_ACC_MAX_EN
    chk("reset_out_max", 32'(bus.out_max), 32'd0);
`endif

    // Back-to-back block, then a stalled block.
    put(3, 1); put(5, 1); put(7, 1); put(9, 1); idle(1); idle(1);
    put(10, 0); put(20, 0); put(30, 0); put(40, 0);
    idle(0); idle(0); idle(0); idle(1); idle(1);
    // Partial block by flush, next block starts fresh.
    put(6, 1); put(2, 1); cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    put(1, 1); put(2, 1); put(3, 1); put(4, 1); idle(1);
    // Flush with a simultaneous accept, then flush on an empty block.
    put(1, 1); put(1, 1); cyc(1'b1, DW'(4), 1'b1, 1'b1, 1'b0); idle(1);
    cyc(1'b0, '0, 1'b1, 1'b1, 1'b0); idle(1);
    // Consecutive results with no bubble.
    put(7, 1); put(8, 1); put(9, 1);
    cyc(1'b1, DW'(5), 1'b1, 1'b1, 1'b0);
    cyc(1'b1, DW'(11), 1'b1, 1'b1, 1'b0);
    cyc(1'b1, DW'(12), 1'b1, 1'b1, 1'b0); idle(1);
    // Flush and sample offered during a stall must be dropped.
    put(2, 1); cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, DW'(9), 1'b1, 1'b0, 1'b0); idle(0); idle(1); idle(1);
    // Reset mid-block and mid-stall.
    put(5, 1); put(5, 1); cyc(1'b1, DW'(3), 1'b0, 1'b1, 1'b1);
    put(1, 1); put(1, 1); put(1, 1); put(1, 1); idle(1);
    put(9, 0); put(1023, 0); put(0, 0); put(7, 0); idle(0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1); idle(1);
    put(9, 1); put(1023, 1); put(0, 1); put(7, 1); idle(1); idle(1);

    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 99) < 70), DW'($urandom_range(0, 1023)),
          1'($urandom_range(0, 99) < 12), 1'($urandom_range(0, 99) < 65),
          1'($urandom_range(0, 199) == 0));
    end

    for (int i = 0; i < 20 && (exp_q.size() > 0 || m_pend); i++) idle(1);
    idle(1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sad_acc.md
SAD_ACC -- requirements
Module: sad_acc

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the sample width of the upstream SAD source; each input sample is W+2 bits.
REQ-002 The block SHALL have parameter LOGN, default 4, meaning the block length is N = 2^LOGN samples.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset; reset is synchronous and active-high.
REQ-005 Port in_vld, input, 1 bit: upstream sample valid; connects to the SAD stage's sad_vld.
REQ-006 Port in_data, input, W+2 bits: upstream SAD sample; connects to sad_res.
REQ-007 Port in_rdy, output, 1 bit: consumer ready; drives the SAD stage's rdy_dn.
REQ-008 Port flush, input, 1 bit: single-cycle request to emit a partial block.
REQ-009 Port out_vld, output, 1 bit: block result valid.
REQ-010 Port out_rdy, input, 1 bit: downstream ready.
REQ-011 Port out_sum, output, W+2+LOGN bits: block sum of absolute differences.
REQ-012 Port out_cnt, output, LOGN+1 bits: number of samples contained in out_sum (1..N).

Function
REQ-013 Input acceptance: a sample SHALL be accepted on a cycle with in_vld & in_rdy.
REQ-014 in_rdy SHALL be combinational: ~out_vld | out_rdy, giving the same bubble-free backpressure rule as the SAD pipeline stages.
REQ-015 Internal registers: acc (W+2+LOGN bits) and cnt (LOGN+1 bits); both are 0 after reset.
REQ-016 Non-final accept (cnt < N-1, no flush): acc <= acc + in_data and cnt <= cnt + 1; the add is unsigned and zero-extended, and overflow is impossible by construction of the width.
REQ-017 Final accept (cnt == N-1): out_sum <= acc + in_data, out_cnt <= N, out_vld <= 1, acc <= 0, cnt <= 0, all in the same edge. Latency from the last sample accept to out_vld is 1 cycle.
REQ-018 Flush with cnt > 0 and no accept, accepted only while in_rdy = 1: out_sum <= acc, out_cnt <= cnt, out_vld <= 1, acc <= 0, cnt <= 0.
REQ-019 Flush with a simultaneous accept: the accepted sample SHALL be included, so out_sum <= acc + in_data and out_cnt <= cnt + 1; the block is then cleared.
REQ-020 Flush with cnt == 0 and no accept SHALL be ignored, with no output.
REQ-021 Flush while in_rdy = 0 SHALL be ignored, not queued.
REQ-022 out_vld clears on out_vld & out_rdy unless a new result loads on the same edge, in which case out_vld stays 1 and the output registers take the new values.
REQ-023 While out_vld & ~out_rdy: out_sum, out_cnt and out_vld SHALL hold stable, in_rdy = 0, and acc and cnt are unchanged.
REQ-024 Control state is the pair {EMPTY: out_vld = 0; FULL: out_vld = 1}.
REQ-025 EMPTY -> FULL on final accept or valid flush.
REQ-026 FULL -> EMPTY on an output handshake with no new result.
REQ-027 FULL -> FULL on an output handshake combined with a new result, or on a stall.

Reset
REQ-028 On rst = 1 at a clk edge: acc = 0, cnt = 0, out_vld = 0, out_sum = 0, out_cnt = 0.
REQ-029 in_rdy SHALL read 1 during and after reset.
REQ-030 Reset mid-block or mid-stall SHALL discard the partial sum and any pending result with no output; rst has priority over all other inputs.

Configuration
REQ-031 With macro SAD_ACC_MAX_EN defined, the block SHALL add output port out_max (W+2 bits), registered alongside out_sum.
REQ-032 out_max is the maximum in_data of the block and includes any sample accepted together with a flush.
REQ-033 The internal maximum tracker resets to 0 at reset and on each block emission.
REQ-034 Without SAD_ACC_MAX_EN, port out_max and its logic SHALL be absent and all other behaviour is identical.

Verification
REQ-035 Back-to-back: W=8, LOGN=2, out_rdy=1, samples 3,5,7,9 on consecutive cycles -> out_vld=1 for one cycle after the 4th accept, out_sum=24, out_cnt=4, in_rdy stays 1.
REQ-036 Stall: a block of 10,20,30,40 completes, out_rdy=0 for 3 cycles -> in_rdy=0, out_sum holds 100; out_rdy=1 -> handshake occurs, then in_rdy=1 on the same cycle.
REQ-037 Flush: samples 6,2 then flush with no in_vld -> out_sum=8, out_cnt=2; the next block starts from 0.
REQ-038 Simultaneous events: flush together with accept of 4 after 1,1 -> out_sum=6, out_cnt=3.
REQ-039 Handshake plus final accept on one cycle: out_vld stays 1 and the new sum appears with no bubble.
REQ-040 Reset mid-block: samples 5,5 then rst for 1 cycle, then 1,1,1,1 -> out_sum=4, out_cnt=4; with SAD_ACC_MAX_EN, samples 9,1023,0,7 -> out_max=1023, out_sum=1039.
